rocc_accum_unit: RTL and testbench

// - Accelerator-side RoCC endpoint. Accepts rocc_cmd_t commands over valid/ready and

---
 rtl/rocc_accum_unit.sv | 186 ++++++++++++++++++
 tb/tb_rocc_accum_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rocc_accum_unit.sv
// RoCC accumulator endpoint: command FIFO feeding a small FSM that runs
// load/add/multiply/read operations on a bank of 64-bit accumulators.
// Each command produces one response, returned in arrival order.

package rocc_accum_pkg;
    typedef struct packed {
        logic [31:0] cmd_instr;
        logic [63:0] cmd_rs1;
        logic [63:0] cmd_rs2;
    } rocc_cmd_t;

    typedef struct packed {
        logic [4:0]  resp_rd;
        logic [63:0] resp_data;
    } rocc_resp_t;
endpackage

module rocc_accum_unit
    import rocc_accum_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 2,
    parameter int unsigned NUM_ACC   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rocc_cmd_t  cmd_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    output rocc_resp_t resp_o,
    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic       busy_o
);
    localparam int unsigned PtrW    = $clog2(CMD_DEPTH);
    localparam int unsigned AccIdxW = $clog2(NUM_ACC);

    typedef enum logic [1:0] {StIdle, StExecMul, StResp} state_e;

    state_e state_q, state_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0] wptr_q, rptr_q;
    rocc_cmd_t     fifo_q [CMD_DEPTH];
    logic          empty, full, push, pop;

    logic [63:0] acc_q [NUM_ACC];
    logic [63:0] resp_q, resp_d;

    // Shift-add multiplier state: partial product, shifting multiplicand and multiplier.
    logic [63:0]        mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [AccIdxW-1:0] midx_q, midx_d;

    logic               acc_we;
    logic [AccIdxW-1:0] acc_widx;
    logic [63:0]        acc_wdata;

    rocc_cmd_t          head;
    logic [6:0]         op;
    logic [AccIdxW-1:0] idx;
    logic [63:0]        cur, step;
    logic               unused_cmd_bits;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign push  = cmd_valid_i && !full;

    assign head = fifo_q[rptr_q[PtrW-1:0]];
    assign op   = head.cmd_instr[31:25];
    assign idx  = head.cmd_rs2[AccIdxW-1:0];
    assign cur  = acc_q[idx];
    assign step = prod_q + (mplier_q[0] ? mcand_q : 64'h0);

    assign unused_cmd_bits = ^{head.cmd_instr[24:0], head.cmd_rs2[63:AccIdxW]};

    assign cmd_ready_o  = !full;
    assign resp_valid_o = (state_q == StResp);
    assign busy_o       = !empty || (state_q != StIdle);
    assign resp_o       = '{resp_rd: 5'h0, resp_data: resp_q};

    // Command storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q[PtrW-1:0]] <= cmd_i;
        end
    end

    // Next-state, accumulator write and response selection.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        acc_we    = 1'b0;
        acc_widx  = idx;
        acc_wdata = head.cmd_rs1;
        resp_d    = resp_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        midx_d    = midx_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StResp;
                    case (op)
                        7'd0: begin
                            acc_we = 1'b1;
                            resp_d = cur;
                        end
                        7'd1: begin
                            acc_we    = 1'b1;
                            acc_wdata = cur + head.cmd_rs1;
                            resp_d    = cur + head.cmd_rs1;
                        end
                        7'd2: begin
                            mcand_d  = cur;
                            mplier_d = head.cmd_rs1;
                            midx_d   = idx;
                            prod_d   = 64'h0;
                            cnt_d    = 6'd0;
                            state_d  = StExecMul;
                        end
                        7'd3:    resp_d = cur;
                        default: resp_d = 64'h0;
                    endcase
                end
            end
            StExecMul: begin
                prod_d   = step;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[63:1]};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    acc_we    = 1'b1;
                    acc_widx  = midx_q;
                    acc_wdata = step;
                    resp_d    = step;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointers, accumulators and multiplier registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wptr_q   <= '0;
            rptr_q   <= '0;
            resp_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            midx_q   <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            resp_q   <= resp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            midx_q   <= midx_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (acc_we) begin
                acc_q[acc_widx] <= acc_wdata;
            end
        end
    end
endmodule

// File: tb/tb_rocc_accum_unit.sv
// Bench for rocc_accum_unit: directed scenarios plus randomized commands
// checked against an arithmetic model of the accumulator bank.

module tb_rocc_accum_unit;
    import rocc_accum_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    rocc_cmd_t  cmd = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    rocc_resp_t resp;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       busy;

    int unsigned total = 0;
    int unsigned passed = 0;

    logic [63:0] m_acc [4];
    logic [63:0] exp_q [$];

    rocc_accum_unit #(
        .CMD_DEPTH(2),
        .NUM_ACC  (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_i       (cmd),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .resp_o      (resp),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference behaviour of one command; returns the response it must produce.
    function automatic logic [63:0] model(input logic [6:0] op, input logic [63:0] rs2,
                                          input logic [63:0] rs1);
        int unsigned i = int'(rs2 % 64'd4);
        logic [63:0] old = m_acc[i];
        case (op)
            7'd0: begin m_acc[i] = rs1; return old; end
            7'd1: begin m_acc[i] = old + rs1; return m_acc[i]; end
            7'd2: begin m_acc[i] = old * rs1; return m_acc[i]; end
            7'd3: return old;
            default: return 64'h0;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m_acc[i] = 64'h0;
        exp_q.delete();
    endtask

    // Returns #1 after the edge at which the command was pushed.
    task automatic send(input logic [6:0] op, input logic [63:0] rs2, input logic [63:0] rs1);
        int n = 0;
        cmd.cmd_instr = {op, 25'($urandom)};
        cmd.cmd_rs1   = rs1;
        cmd.cmd_rs2   = rs2;
        cmd_valid     = 1'b1;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_q.push_back(model(op, rs2, rs1));
    endtask

    task automatic recv(input string tag, input int hold);
        int n = 0;
        logic [63:0] exp;
        resp_ready = 1'b0;
        repeat (hold) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        while (!resp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        chk({tag, "_valid"}, 64'(resp_valid), 64'h1);
        chk(tag, resp.resp_data, exp);
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // Edges from the push until resp_valid is seen.
    task automatic latency(output int n);
        n = 0;
        while (!resp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [6:0] op;
        clear_model();
        #12;
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        chk("rst_resp_data", resp.resp_data, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: LOAD then READ
        send(7'd0, 64'd1, 64'h1234);
        latency(n);
        chk("load_latency", 64'(n), 64'd1);
        recv("t1_load", 0);
        send(7'd3, 64'd1, 64'h0);
        recv("t1_read", 1);

        // T2: ADD wraps modulo 2^64
        send(7'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        recv("t2_load", 0);
        send(7'd1, 64'd0, 64'd2);
        recv("t2_add", 0);
        send(7'd3, 64'd0, 64'h0);
        recv("t2_read", 0);

        // T3: MUL result and latency
        send(7'd0, 64'd2, 64'd7);
        recv("t3_load", 0);
        send(7'd2, 64'd2, 64'd6);
        latency(n);
        chk("mul_latency", 64'(n), 64'd65);
        recv("t3_mul", 0);
        send(7'd0, 64'd3, 64'h1_0000_0000);
        recv("t3_load2", 0);
        send(7'd2, 64'd3, 64'h1_0000_0000);
        recv("t3_mul_ovf", 0);

        // T4: backpressure and FIFO full
        send(7'd3, 64'd1, 64'h0);
        send(7'd2 + 7'd1, 64'd2, 64'h0);
        send(7'd3, 64'd0, 64'h0);
        fork
            send(7'd3, 64'd3, 64'h0);
            begin
                repeat (3) begin @(posedge clk); #1; end
                chk("t4_full_ready", 64'(cmd_ready), 64'h0);
                chk("t4_busy", 64'(busy), 64'h1);
                chk("t4_hold_valid", 64'(resp_valid), 64'h1);
                chk("t4_hold_data0", resp.resp_data, exp_q[0]);
                repeat (2) begin @(posedge clk); #1; end
                chk("t4_hold_data1", resp.resp_data, exp_q[0]);
                for (int k = 0; k < 4; k++) recv($sformatf("t4_resp%0d", k), 0);
            end
        join

        // T5: illegal op and index aliasing
        send(7'd0, 64'h5, 64'hDEAD_BEEF_0000_0001);
        recv("t5_load_alias", 0);
        send(7'd3, 64'h1, 64'h0);
        recv("t5_read_alias", 0);
        send(7'd9, 64'h1, 64'hFFFF);
        recv("t5_illegal", 0);
        send(7'd3, 64'h1, 64'h0);
        recv("t5_read_after_illegal", 0);

        // Randomized commands with random response backpressure
        for (int it = 0; it < 24; it++) begin
            op = 7'($urandom_range(0, 4));
            if (op == 7'd4) op = 7'($urandom_range(4, 127));
            send(op, {$urandom, $urandom}, {$urandom, $urandom});
            recv($sformatf("rand%0d_op%0d", it, op), int'($urandom_range(0, 3)));
        end

        // T6: reset during EXEC_MUL at counter 20, with a command queued behind it
        send(7'd0, 64'd2, 64'd5);
        recv("t6_load", 0);
        send(7'd2, 64'd2, 64'd3);
        send(7'd3, 64'd1, 64'h0);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        clear_model();
        #2;
        chk("t6_rst_valid", 64'(resp_valid), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_ready", 64'(cmd_ready), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_post_valid", 64'(resp_valid), 64'h0);
        chk("t6_post_busy", 64'(busy), 64'h0);
        send(7'd3, 64'd2, 64'h0);
        recv("t6_read_cleared", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
